int_request_ctrl: RTL

- Interrupt initiator for the pipeline timing controller.
- Edge-captures external IRQ lines, masks and prioritises them, then raises the pipeline-flush request (`int_ask`) and waits out any stall.
- Redirects fetch to the handler vector, saves the return PC, and on `reti` flushes again and redirects back to the saved PC.
- Sits between the IRQ pins, the execute stage (`reti`, `ret_pc`) and the load stage (jump redirect).

---
 rtl/int_pkg.sv | 25 ++
 rtl/int_prio_enc.sv | 27 ++
 rtl/int_request_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt request controller.
//   int_state_e       : controller FSM states
//   INT_VECTOR_BASE   : default handler address for IRQ 0
//   INT_VECTOR_STRIDE : default byte distance between handler vectors
//   id_w()            : width of an IRQ index for a given line count
package int_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    VEC     = 3'd2,
    SERVICE = 3'd3,
    RET     = 3'd4,
    RJMP    = 3'd5
  } int_state_e;

  localparam logic [31:0] INT_VECTOR_BASE   = 32'h0000_0100;
  localparam int          INT_VECTOR_STRIDE = 16;

  // Never narrower than one bit, so a 2-line build still has a usable ID.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req wins.
// Ports:
//   req   in  N     request vector
//   valid out 1     at least one request bit set
//   id    out ID_W  index of the winning request (0 when none)
module int_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scanning downward lets the lowest index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt initiator for the pipeline timing controller.
// Edge-captures IRQ lines, masks and prioritises them, requests a pipeline
// flush, redirects fetch to the handler vector, and on reti flushes again
// and redirects back to the saved return PC.
//
// Build option: define INT_NEST_EN to allow a lower-index interrupt to
// preempt a running handler, with a NEST_DEPTH-entry return stack.
//
// Ports:
//   clk         in   1        core clock
//   rst_n       in   1        asynchronous active-low reset
//   irq         in   IRQ_NUM  level IRQ lines, synchronous to clk
//   irq_mask    in   IRQ_NUM  1 = line enabled
//   gie         in   1        global interrupt enable
//   stall_in    in   1        pipeline freeze
//   cpu_rst_in  in   1        synchronous CPU restart
//   ret_pc      in   ADDR_W   PC of the oldest uncommitted instruction
//   reti_in     in   1        execute retired a reti (one-cycle pulse)
//   int_ask     out  1        pipeline-flush request
//   jump_en     out  1        one-cycle fetch redirect strobe
//   jump_addr   out  ADDR_W   redirect target, valid with jump_en
//   in_service  out  1        a handler is running
//   active_id   out  ID_W     ID of the IRQ being serviced
//   pending     out  IRQ_NUM  pending register
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no handler running; accept the best enabled pending IRQ
// REQ     | int_ask high; waiting for an unstalled cycle to flush
// VEC     | jump_en to the handler vector, epc already saved
// SERVICE | handler running; waiting for reti
// RET     | int_ask high; waiting for an unstalled cycle to flush
// RJMP    | jump_en back to epc
module int_request_ctrl
  import int_pkg::*;
#(
  parameter int          IRQ_NUM       = 8,
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] VECTOR_BASE   = INT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = INT_VECTOR_STRIDE,
  parameter int          NEST_DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IRQ_NUM-1:0]         irq,
  input  logic [IRQ_NUM-1:0]         irq_mask,
  input  logic                       gie,
  input  logic                       stall_in,
  input  logic                       cpu_rst_in,
  input  logic [ADDR_W-1:0]          ret_pc,
  input  logic                       reti_in,
  output logic                       int_ask,
  output logic                       jump_en,
  output logic [ADDR_W-1:0]          jump_addr,
  output logic                       in_service,
  output logic [id_w(IRQ_NUM)-1:0]   active_id,
  output logic [IRQ_NUM-1:0]         pending
);

  localparam int ID_W = id_w(IRQ_NUM);
  localparam logic [IRQ_NUM-1:0] IRQ_ONE = IRQ_NUM'(1);

  if (IRQ_NUM < 2 || IRQ_NUM > 32 || NEST_DEPTH < 1) begin : g_param_chk
    $error("int_request_ctrl: IRQ_NUM must be 2..32 and NEST_DEPTH >= 1");
  end

  int_state_e          state;
  logic [IRQ_NUM-1:0]  irq_q;
  logic [IRQ_NUM-1:0]  rise;
  logic [IRQ_NUM-1:0]  cand;
  logic [IRQ_NUM-1:0]  clr;
  logic                cand_valid;
  logic [ID_W-1:0]     cand_id;
  logic                accept;
  logic [ADDR_W-1:0]   epc;
  logic [ADDR_W-1:0]   vec_addr;

  assign rise = irq & ~irq_q;
  assign cand = pending & irq_mask;

  int_prio_enc #(
    .N    (IRQ_NUM),
    .ID_W (ID_W)
  ) u_prio (
    .req   (cand),
    .valid (cand_valid),
    .id    (cand_id)
  );

  // active_id is already frozen by the time the vector is needed.
  assign vec_addr = ADDR_W'(VECTOR_BASE) + ADDR_W'(active_id) * ADDR_W'(VECTOR_STRIDE);

`ifdef INT_NEST_EN
  localparam int SP_W = $clog2(NEST_DEPTH + 1);
  localparam int IX_W = (NEST_DEPTH <= 1) ? 1 : $clog2(NEST_DEPTH);

  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] epc_stk [NEST_DEPTH];
  logic [ID_W-1:0]   id_stk  [NEST_DEPTH];
  logic [IX_W-1:0]   push_ix;
  logic [IX_W-1:0]   pop_ix;
  logic              stk_full;
  logic              stk_empty;
  logic              preempt;

  assign push_ix   = IX_W'(sp);
  assign pop_ix    = IX_W'(sp - SP_W'(1));
  assign stk_full  = (sp == SP_W'(NEST_DEPTH));
  assign stk_empty = (sp == '0);

  // A retiring handler is not preempted; the new IRQ stays pending and is
  // reconsidered once the return has completed.
  assign preempt = (state == SERVICE) && !reti_in && gie && cand_valid &&
                   (cand_id < active_id) && !stk_full;

  always_comb begin
    accept = 1'b0;
    if ((state == IDLE) && gie && cand_valid) accept = 1'b1;
    if (preempt) accept = 1'b1;
  end
`else
  always_comb begin
    accept = 1'b0;
    if ((state == IDLE) && gie && cand_valid) accept = 1'b1;
  end
`endif

  assign clr = accept ? (IRQ_ONE << cand_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq_q      <= '0;
      pending    <= '0;
      epc        <= '0;
      int_ask    <= 1'b0;
      jump_en    <= 1'b0;
      jump_addr  <= '0;
      in_service <= 1'b0;
      active_id  <= '0;
`ifdef INT_NEST_EN
      sp         <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        epc_stk[i] <= '0;
        id_stk[i]  <= '0;
      end
`endif
    end else if (cpu_rst_in) begin
      state      <= IDLE;
      irq_q      <= '0;
      pending    <= '0;
      epc        <= '0;
      int_ask    <= 1'b0;
      jump_en    <= 1'b0;
      jump_addr  <= '0;
      in_service <= 1'b0;
      active_id  <= '0;
`ifdef INT_NEST_EN
      sp         <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        epc_stk[i] <= '0;
        id_stk[i]  <= '0;
      end
`endif
    end else begin
      irq_q   <= irq;
      // A fresh edge on the accepted line re-arms it.
      pending <= (pending & ~clr) | rise;
      jump_en <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            active_id <= cand_id;
            int_ask   <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!stall_in) begin
            epc       <= ret_pc;
            int_ask   <= 1'b0;
            jump_en   <= 1'b1;
            jump_addr <= vec_addr;
            state     <= VEC;
          end
        end

        VEC: begin
          in_service <= 1'b1;
          state      <= SERVICE;
        end

        SERVICE: begin
          if (reti_in) begin
            int_ask <= 1'b1;
            state   <= RET;
          end
`ifdef INT_NEST_EN
          else if (preempt) begin
            epc_stk[push_ix] <= epc;
            id_stk[push_ix]  <= active_id;
            sp               <= sp + SP_W'(1);
            active_id        <= cand_id;
            int_ask          <= 1'b1;
            state            <= REQ;
          end
`endif
        end

        RET: begin
          if (!stall_in) begin
            int_ask   <= 1'b0;
            jump_en   <= 1'b1;
            jump_addr <= epc;
`ifdef INT_NEST_EN
            in_service <= !stk_empty;
`else
            in_service <= 1'b0;
`endif
            state     <= RJMP;
          end
        end

        RJMP: begin
`ifdef INT_NEST_EN
          if (!stk_empty) begin
            epc       <= epc_stk[pop_ix];
            active_id <= id_stk[pop_ix];
            sp        <= sp - SP_W'(1);
            state     <= SERVICE;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
